// File: rtl/fetch_sequencer_pkg.sv
// Shared types and helpers for the fetch sequencer: FSM encoding, reset vector,
// and the branch/jump target computation.
package fetch_sequencer_pkg;

  localparam logic [31:0] RESET_VEC_DEF = 32'h3000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // A taken branch wins over a jump. Both targets are relative to the fall-through PC.
  function automatic logic [31:0] next_pc_target(
    input logic [31:0] redir_pc,
    input logic        br_taken,
    input logic [31:0] br_offset,
    input logic [25:0] jmp_target
  );
    logic [31:0] seq;
    seq = redir_pc + 32'd4;
    if (br_taken) return seq + (br_offset << 2);
    return {seq[31:28], jmp_target, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: execute redirects,
// the imem request/ack port and the decode valid/ready port.
interface fetch_sequencer_if #(parameter int AW = 32);
  logic [AW-1:0] redir_pc;
  logic          br_taken;
  logic [31:0]   br_offset;
  logic          jmp;
  logic [25:0]   jmp_target;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [AW-1:0] if_pc;

  modport master (
    input  redir_pc, br_taken, br_offset, jmp, jmp_target, imem_ack, imem_rdata, if_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output redir_pc, br_taken, br_offset, jmp, jmp_target, imem_ack, imem_rdata, if_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc
  );
endinterface

// File: rtl/fetch_target_calc.sv
// Combinational redirect decode: flags a redirect and selects the branch or jump target.
module fetch_target_calc
  import fetch_sequencer_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] redir_pc,
  input  logic          br_taken,
  input  logic [31:0]   br_offset,
  input  logic          jmp,
  input  logic [25:0]   jmp_target,
  output logic          redir,
  output logic [AW-1:0] target
);
  assign redir  = br_taken | jmp;
  assign target = AW'(next_pc_target(32'(redir_pc), br_taken, br_offset, jmp_target));
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one imem request at a time, fetched word held for
// decode until accepted, execute redirects squash whatever is in progress.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter int          AW        = 32
) (
  input logic               clk,
  input logic               rst,
  fetch_sequencer_if.master bus
);
  state_t        state, state_n;
  logic [AW-1:0] pc, pc_n;
  logic          discard, discard_n;
  logic          vld_q, vld_n;
  logic [31:0]   instr_q, instr_n;
  logic [AW-1:0] ipc_q, ipc_n;
  logic          redir;
  logic [AW-1:0] tgt;

  fetch_target_calc #(.AW(AW)) u_tgt (
    .redir_pc   (bus.redir_pc),
    .br_taken   (bus.br_taken),
    .br_offset  (bus.br_offset),
    .jmp        (bus.jmp),
    .jmp_target (bus.jmp_target),
    .redir      (redir),
    .target     (tgt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_REQ;
      pc      <= AW'(RESET_VEC);
      discard <= 1'b0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      vld_q   <= vld_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    vld_n     = vld_q;
    instr_n   = instr_q;
    ipc_n     = ipc_q;
    case (state)
      S_REQ: begin
        // A redirect beats a same-cycle ack: the returned word belongs to the old path.
        if (redir) pc_n = tgt;
        else if (bus.imem_ack) begin
          instr_n = bus.imem_rdata;
          ipc_n   = pc;
          vld_n   = 1'b1;
          state_n = S_HOLD;
        end
      end
      S_WAIT: begin
        if (redir) pc_n = tgt;
        if (bus.imem_ack) begin
          discard_n = 1'b0;
          state_n   = S_REQ;
        end
      end
      S_HOLD: begin
        // imem_ack here is a protocol violation and is ignored.
        if (redir) begin
          pc_n    = tgt;
          vld_n   = 1'b0;
          state_n = S_REQ;
        end else if (bus.if_ready) begin
          pc_n    = pc + AW'(4);
          vld_n   = 1'b0;
          state_n = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  assign bus.imem_req  = (state == S_REQ) && !rst;
  assign bus.imem_addr = {pc[AW-1:2], 2'b00};
  assign bus.if_valid  = vld_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = ipc_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle vector table plus hand sequences
// for decode stall and reset during an acked request.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.AW(32)) bus ();

  fetch_sequencer #(.RESET_VEC(32'h3000), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        br;
    logic [31:0] off;
    logic        jmp;
    logic [25:0] jt;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic ack, input logic [31:0] rdata, input logic ready,
    input logic br, input logic [31:0] off, input logic jmp, input logic [25:0] jt,
    input logic [31:0] rpc,
    input logic e_req, input logic [31:0] e_addr, input logic e_vld,
    input logic [31:0] e_instr, input logic [31:0] e_pc
  );
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.br = br; v.off = off; v.jmp = jmp; v.jt = jt; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_instr = e_instr; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.imem_ack   = v.ack;
    bus.imem_rdata = v.rdata;
    bus.if_ready   = v.ready;
    bus.br_taken   = v.br;
    bus.br_offset  = v.off;
    bus.jmp        = v.jmp;
    bus.jmp_target = v.jt;
    bus.redir_pc   = v.rpc;
  endtask

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;

    //          ack rdata         rdy br off           jmp jt          rpc           req addr          vld instr         pc
    vt.push_back(mk(1, 32'hA000_0000, 1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h3000, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 26'h0,       32'h0,      0, 32'h0,    1, 32'hA000_0000, 32'h3000));
    vt.push_back(mk(1, 32'hA111_1111, 1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h3004, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 26'h0,       32'h0,      0, 32'h0,    1, 32'hA111_1111, 32'h3004));
    vt.push_back(mk(1, 32'hA222_2222, 1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h3008, 0, 32'h0,        32'h0));
    // branch while word held and decode ready: word squashed, target 0x300C
    vt.push_back(mk(0, 32'h0,         1, 1, 32'hFFFF_FFFE, 0, 26'h0,      32'h3010,   0, 32'h0,    1, 32'hA222_2222, 32'h3008));
    // jump while request pending without ack: target 0x3100
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        1, 26'h0000C40, 32'h3020,   1, 32'h300C, 0, 32'h0,        32'h0));
    // branch+jump with same-cycle ack: word dropped, branch target 0x3008 wins
    vt.push_back(mk(1, 32'hBAD0_BAD0, 1, 1, 32'h1,        1, 26'h3FF_FFFF, 32'h3000,  1, 32'h3100, 0, 32'h0,        32'h0));
    vt.push_back(mk(1, 32'hA333_3333, 1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h3008, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 26'h0,       32'h0,      0, 32'h0,    1, 32'hA333_3333, 32'h3008));
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h300C, 0, 32'h0,        32'h0));
    vt.push_back(mk(1, 32'hA444_4444, 1, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h300C, 0, 32'h0,        32'h0));
    vt.push_back(mk(0, 32'h0,         1, 0, 32'h0,        0, 26'h0,       32'h0,      0, 32'h0,    1, 32'hA444_4444, 32'h300C));
    vt.push_back(mk(1, 32'hA555_5555, 0, 0, 32'h0,        0, 26'h0,       32'h0,      1, 32'h3010, 0, 32'h0,        32'h0));

    // reset state, with imem_ack high to show no request is issued
    @(negedge clk); #1;
    chk("rst_req",   32'(bus.imem_req), 32'd0);
    chk("rst_vld",   32'(bus.if_valid), 32'd0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_pc",    bus.if_pc, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(vt[i]);
      #1;
      if (bus.imem_ack && bus.if_valid) begin
        failed++;
        $display("FAIL ack_in_hold v%0d: imem_ack=1 with if_valid=1, required no ack", i);
      end
      chk($sformatf("v%0d_req", i), 32'(bus.imem_req), 32'(vt[i].e_req));
      if (vt[i].e_req) chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_vld", i), 32'(bus.if_valid), 32'(vt[i].e_vld));
      if (vt[i].e_vld) begin
        chk($sformatf("v%0d_instr", i), bus.if_instr, vt[i].e_instr);
        chk($sformatf("v%0d_pc", i), bus.if_pc, vt[i].e_pc);
      end
    end

    // decode stall: word at 0x3010 held for 5 cycles, no new request
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(idle);
      #1;
      chk($sformatf("stall%0d_vld", i), 32'(bus.if_valid), 32'd1);
      chk($sformatf("stall%0d_instr", i), bus.if_instr, 32'hA555_5555);
      chk($sformatf("stall%0d_pc", i), bus.if_pc, 32'h3010);
      chk($sformatf("stall%0d_req", i), 32'(bus.imem_req), 32'd0);
    end
    @(negedge clk);
    bus.if_ready = 1'b1;
    #1;
    chk("stall_release_vld", 32'(bus.if_valid), 32'd1);
    @(negedge clk);
    bus.if_ready = 1'b0;
    #1;
    chk("after_stall_req",  32'(bus.imem_req), 32'd1);
    chk("after_stall_addr", bus.imem_addr, 32'h3014);
    chk("after_stall_vld",  32'(bus.if_valid), 32'd0);

    // reset in S_REQ with an ack in the same cycle: word abandoned, restart at 0x3000
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD1_BAD1;
    #1;
    chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    #1;
    chk("post_rst_vld",  32'(bus.if_valid), 32'd0);
    chk("post_rst_req",  32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h3000);
    @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hC000_0000;
    #1;
    chk("post_rst_addr2", bus.imem_addr, 32'h3000);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    #1;
    chk("post_rst_fetch_vld",   32'(bus.if_valid), 32'd1);
    chk("post_rst_fetch_instr", bus.if_instr, 32'hC000_0000);
    chk("post_rst_fetch_pc",    bus.if_pc, 32'h3000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
